// File: rtl/uart_pkg.sv
// Shared UART constants. The receiver and the receive FIFO both import this package,
// so they agree on the byte width and the buffer depth.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int CLOCK_FREQ  = 50_000_000;
  localparam int BAUD_RATE   = 115200;
  localparam int BAUD_DIV    = CLOCK_FREQ / BAUD_RATE;
  localparam int FIFO_DEPTH  = 16;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage with a synchronous write port and an asynchronous read port.
// The storage has no reset, so it can be inferred as distributed RAM.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH  = FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]      i_rd_addr,
  output logic [UART_DATA_W-1:0] o_rd_data
);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver. It tracks occupancy and
// almost-full, and records bytes dropped on overflow in a sticky flag and a saturating counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH    = FIFO_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 4,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_ready,
  output logic [UART_DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W:0]        count,
  output logic                   almost_full,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic [7:0]             drop_count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);

  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W:0]        r_count;
  logic                   r_overrun;
  logic [7:0]             r_drop_count;

  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [UART_DATA_W-1:0] w_rd_data;

  assign out_valid   = (r_count != '0);
  assign almost_full = (r_count >= AF_CNT);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign w_push      = rx_ready & (~w_full | w_pop);
  assign w_drop      = rx_ready & w_full & ~w_pop;

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk     (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (rx_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // The storage is not reset, so the head byte is masked while the FIFO is empty.
  assign out_data = out_valid ? w_rd_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, so that drop is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (overrun_clr)               r_drop_count <= 8'd1;
      else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
    end else if (overrun_clr) begin
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign count      = r_count;
  assign overrun    = r_overrun;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DEPTH=16: latency, fill/drain order, overflow,
// simultaneous push/pop at the full and empty boundaries, and asynchronous reset.
module tb_uart_rx_fifo;
  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       almost_full;
  logic       overrun;
  logic       overrun_clr;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic       m_ovr;
  int         m_drop;

  uart_rx_fifo dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .drop_count  (drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovr  = 1'b0;
    m_drop = 0;
  endtask

  // One clock with the given inputs; the model follows the same push/pop/drop rules.
  task automatic cycle(input logic push, input logic [7:0] d, input logic rdy, input logic clr);
    logic pop;
    logic full;
    rx_ready    = push;
    rx_data     = d;
    out_ready   = rdy;
    overrun_clr = clr;
    pop  = (exp_q.size() > 0) && rdy;
    full = (exp_q.size() == 16);
    if (pop) chk("pop_data", out_data, exp_q[0]);
    @(posedge clk);
    #1;
    rx_ready    = 1'b0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (push && (!full || pop)) exp_q.push_back(d);
    if (push && full && !pop) begin
      m_ovr  = 1'b1;
      m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovr  = 1'b0;
      m_drop = 0;
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
    chk({tag, "_af"}, 32'(almost_full), 32'(exp_q.size() >= 12));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
    chk({tag, "_data"}, 32'(out_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk({tag, "_empty"}, 32'(out_valid), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; rx_data = '0; rx_ready = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_status("reset");
    chk("reset_data_zero", 32'(out_data), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single byte latency, then one pop
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_count", 32'(count), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_pop_valid", 32'(out_valid), 32'h0);
    chk("t1_pop_count", 32'(count), 32'h0);

    // fill to full; almost_full from count 12
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_af", 32'(almost_full), 32'(i >= 11));
    end
    chk("full_count", 32'(count), 32'd16);
    check_status("full");

    // drop at full, then clear
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("drop_ovr", 32'(overrun), 32'h1);
    chk("drop_cnt", 32'(drop_count), 32'h1);
    chk("drop_count", 32'(count), 32'd16);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovr", 32'(overrun), 32'h0);
    chk("clr_cnt", 32'(drop_count), 32'h0);

    // push with pop at full: head 00 leaves, 55 joins at the tail
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_ovr", 32'(overrun), 32'h0);
    chk("pp_head", 32'(out_data), 32'h01);
    chk("pp_tail", 32'(exp_q[15]), 32'h55);
    drain("drain1");
    check_status("drained");

    // empty: out_ready ignored, push accepted
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    chk("e_valid", 32'(out_valid), 32'h1);
    chk("e_data", 32'(out_data), 32'h3C);
    chk("e_count", 32'(count), 32'h1);
    drain("drain2");

    // drop_count saturation, then clear coinciding with a drop
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'hDD, 1'b0, 1'b0);
    chk("sat_cnt", 32'(drop_count), 32'd255);
    chk("sat_ovr", 32'(overrun), 32'h1);
    cycle(1'b1, 8'hDD, 1'b0, 1'b1);
    chk("clrdrop_ovr", 32'(overrun), 32'h1);
    chk("clrdrop_cnt", 32'(drop_count), 32'h1);
    check_status("clrdrop");
    drain("drain3");

    // async reset mid-cycle with 10 bytes queued and overrun still set
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd10);
    chk("pre_rst_ovr", 32'(overrun), 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_ovr", 32'(overrun), 32'h0);
    chk("arst_drop", 32'(drop_count), 32'h0);
    chk("arst_data", 32'(out_data), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h81, 1'b0, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h81);
    chk("post_rst_count", 32'(count), 32'h1);
    drain("drain4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
